// File: rtl/wf_gather_queue_if.sv
// Handshake and RAM-port bundle for the wavefront gather queue.
// master = the queue itself; slave = producer/consumer/RAM side.
interface wf_gather_queue_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 39,
   parameter int AW    = 3
);
   // enqueue side
   logic             enq_valid;
   logic             enq_ready;
   logic [WIDTH-1:0] enq_bits;
   // dequeue side
   logic             deq_valid;
   logic             deq_ready;
   logic [WIDTH-1:0] deq_bits;
   // occupancy
   logic [AW:0]      count;
   // gather RAM write port
   logic             ram_W0_en;
   logic [AW-1:0]    ram_W0_addr;
   logic [WIDTH-1:0] ram_W0_data;
   // gather RAM registered-read port
   logic             ram_R0_en;
   logic [AW-1:0]    ram_R0_addr;
   logic [WIDTH-1:0] ram_R0_data;

   modport master (
      input  enq_valid, enq_bits, deq_ready, ram_R0_data,
      output enq_ready, deq_valid, deq_bits, count,
             ram_W0_en, ram_W0_addr, ram_W0_data,
             ram_R0_en, ram_R0_addr
   );

   modport slave (
      output enq_valid, enq_bits, deq_ready, ram_R0_data,
      input  enq_ready, deq_valid, deq_bits, count,
             ram_W0_en, ram_W0_addr, ram_W0_data,
             ram_R0_en, ram_R0_addr
   );
endinterface

// File: rtl/wf_gather_queue.sv
// FIFO controller in front of an external 2-port gather RAM. Writes go
// straight to the RAM; the head entry is prefetched through the RAM's
// registered read port so the consumer sees a plain valid/ready head.
module wf_gather_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 39,
   parameter int AW    = 3
) (
   input  logic              clock,
   input  logic              reset,
   wf_gather_queue_if.master bus
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   unread_q, unread_d;
   logic          head_valid_q, head_valid_d;

   logic enq_fire;
   logic deq_fire;
   logic issue;

   // Handshakes. enq_ready looks only at the registered count, so a full
   // queue refuses a write even when the head leaves in the same cycle.
   always_comb begin
      bus.enq_ready = (count_q != FULL);
      bus.deq_valid = head_valid_q;
      bus.deq_bits  = bus.ram_R0_data;
      bus.count     = count_q;
      enq_fire      = bus.enq_valid & bus.enq_ready;
      deq_fire      = head_valid_q & bus.deq_ready;
      // Refill the head slot when it is empty or being consumed. Entries
      // written this cycle are not in unread yet, so no read/write overlap.
      issue         = (unread_q != '0) & (~head_valid_q | deq_fire) & ~reset;
   end

   // RAM port drive: write on accepted enqueue, read on prefetch issue.
   always_comb begin
      bus.ram_W0_en   = enq_fire;
      bus.ram_W0_addr = wr_ptr_q;
      bus.ram_W0_data = bus.enq_bits;
      bus.ram_R0_en   = issue;
      bus.ram_R0_addr = rd_ptr_q;
   end

   // Next-state for pointers, occupancy and the prefetched head flag.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      unread_d     = unread_q;
      head_valid_d = head_valid_q;
      if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (issue)    rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q + (AW+1)'(enq_fire) - (AW+1)'(deq_fire);
      unread_d = unread_q + (AW+1)'(enq_fire) - (AW+1)'(issue);
      if (issue)
         head_valid_d = 1'b1;
      else if (deq_fire)
         head_valid_d = 1'b0;
   end

   // State registers; reset drops any prefetched head, RAM is left alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         unread_q     <= '0;
         head_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         unread_q     <= unread_d;
         head_valid_q <= head_valid_d;
      end
   end

endmodule

// File: tb/tb_wf_gather_queue.sv
// Randomised bench for wf_gather_queue with a behavioural RAM and a
// transaction-level reference model (entry queue + per-entry timing).
module tb_wf_gather_queue;
   localparam int DEPTH = 8;
   localparam int WIDTH = 39;
   localparam int AW    = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   wf_gather_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus();

   wf_gather_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // External RAM: synchronous write, registered read held between reads.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata;
   always @(posedge clock) begin
      if (bus.ram_W0_en) mem[bus.ram_W0_addr] <= bus.ram_W0_data;
      if (bus.ram_R0_en) rdata <= mem[bus.ram_R0_addr];
   end
   assign bus.ram_R0_data = rdata;

   // Reference model: each entry remembers the cycle it was written.
   // Entry k is fetched at max(write+1, dequeue cycle of entry k-1) and
   // becomes visible the cycle after that.
   typedef struct {
      logic [WIDTH-1:0] d;
      int               w;
   } ent_t;
   ent_t q[$];
   int   cyc;
   int   last_deq;
   int   wseq;
   int   riss;
   int   n_chk;
   int   n_fail;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] rnd();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[WIDTH-1:0];
   endfunction

   task automatic model_reset();
      q.delete();
      last_deq = -100;
      wseq     = 0;
      riss     = 0;
   endtask

   // Compare all DUT outputs for the current cycle, then advance the model.
   task automatic check_cycle();
      bit   exp_rdy, exp_v, exp_ef, exp_df, exp_iss;
      int   i0;
      ent_t e;
      exp_rdy = (q.size() != DEPTH);
      exp_v   = 1'b0;
      i0      = -1000;
      if (q.size() > 0) begin
         i0    = (q[0].w + 1 > last_deq) ? q[0].w + 1 : last_deq;
         exp_v = (cyc >= i0 + 1);
      end
      exp_ef  = bus.enq_valid && exp_rdy;
      exp_df  = exp_v && bus.deq_ready;
      exp_iss = (q.size() > 0 && cyc == i0) ||
                (exp_df && q.size() > 1 && q[1].w + 1 <= cyc);

      chk("enq_ready", 64'(bus.enq_ready), 64'(exp_rdy));
      chk("count",     64'(bus.count),     64'(q.size()));
      chk("deq_valid", 64'(bus.deq_valid), 64'(exp_v));
      if (exp_v) chk("deq_bits", 64'(bus.deq_bits), 64'(q[0].d));
      chk("w0_en",     64'(bus.ram_W0_en), 64'(exp_ef));
      if (exp_ef) begin
         chk("w0_addr", 64'(bus.ram_W0_addr), 64'(wseq % DEPTH));
         chk("w0_data", 64'(bus.ram_W0_data), 64'(bus.enq_bits));
      end
      chk("r0_en",     64'(bus.ram_R0_en),   64'(exp_iss));
      chk("r0_addr",   64'(bus.ram_R0_addr), 64'(riss % DEPTH));

      if (exp_df) begin
         void'(q.pop_front());
         last_deq = cyc;
      end
      if (exp_ef) begin
         e.d = bus.enq_bits;
         e.w = cyc;
         q.push_back(e);
         wseq++;
      end
      if (exp_iss) riss++;
   endtask

   task automatic tick(input logic ev, input logic dr, input logic [WIDTH-1:0] d);
      bus.enq_valid = ev;
      bus.deq_ready = dr;
      bus.enq_bits  = d;
      @(negedge clock);
      check_cycle();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic pulse_reset();
      reset         = 1'b1;
      bus.enq_valid = 1'b0;
      bus.deq_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      cyc++;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      model_reset();
      bus.enq_valid = 1'b0;
      bus.deq_ready = 1'b0;
      bus.enq_bits  = '0;

      // reset values, observed while reset is still asserted
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("rst_enq_ready", 64'(bus.enq_ready),   64'd1);
      chk("rst_deq_valid", 64'(bus.deq_valid),   64'd0);
      chk("rst_count",     64'(bus.count),       64'd0);
      chk("rst_w0_en",     64'(bus.ram_W0_en),   64'd0);
      chk("rst_r0_en",     64'(bus.ram_R0_en),   64'd0);
      chk("rst_w0_addr",   64'(bus.ram_W0_addr), 64'd0);
      chk("rst_r0_addr",   64'(bus.ram_R0_addr), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // single entry, held under back-pressure, then consumed
      tick(1'b1, 1'b0, 39'h12_3456_789A);
      repeat (4) tick(1'b0, 1'b0, '0);
      repeat (3) tick(1'b0, 1'b1, '0);

      // fill to full; value 8 is held by the producer
      for (int i = 0; i <= 8; i++) tick(1'b1, 1'b0, WIDTH'(i));
      repeat (3) tick(1'b1, 1'b0, WIDTH'(8));
      // full plus simultaneous deq: no enqueue this cycle, then accepted
      tick(1'b1, 1'b1, WIDTH'(8));
      tick(1'b1, 1'b0, WIDTH'(8));
      repeat (12) tick(1'b0, 1'b1, '0);

      // streaming, pointers wrap
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, rnd());
      repeat (4) tick(1'b0, 1'b1, '0);

      // random stalls on both sides
      for (int i = 0; i < 1000; i++)
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rnd());
      repeat (12) tick(1'b0, 1'b1, '0);

      // reset with 5 entries held, then fresh data from slot 0
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, rnd());
      repeat (3) tick(1'b0, 1'b0, '0);
      pulse_reset();
      tick(1'b0, 1'b1, '0);
      tick(1'b1, 1'b0, 39'h55_AAAA_5555);
      tick(1'b1, 1'b0, 39'h2A_0F0F_F0F0);
      repeat (4) tick(1'b0, 1'b0, '0);
      repeat (5) tick(1'b0, 1'b1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
